// File: rtl/spi_sram_master.sv
// SPI mode-0 master for M23A1024-class serial SRAMs. It runs one fixed-length
// full-duplex transfer per request and reports the word shifted in from MISO.
module spi_sram_master #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] d_send,
    output logic [DATA_WIDTH-1:0] d_received,
    output logic                  transfer_success,
    output logic                  HOLD_ENABLE,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sck,
    output logic                  cs_n
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SCK_HI,
        ST_SCK_LO,
        ST_TRAIL
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DIV_W-1:0]      r_div, w_div_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_tx, w_tx_nxt;
    logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt;
    logic [DATA_WIDTH-1:0] r_drx, w_drx_nxt;
    logic                  r_sck, w_sck_nxt;
    logic                  r_mosi, w_mosi_nxt;
    logic                  r_cs_n, w_cs_n_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_hold;
    logic                  w_div_last;

    assign w_div_last = (r_div == DIV_LAST);

    // NOTE: every next-state value gets a default before the case statement,
    // so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_drx_nxt   = r_drx;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_cs_n_nxt  = r_cs_n;
        w_done_nxt  = 1'b0;

        // One shared divider paces every non-idle phase to CLK_DIV cycles.
        if (r_state != ST_IDLE) begin
            w_div_nxt = w_div_last ? '0 : r_div + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_tx_nxt    = d_send;
                    w_cs_n_nxt  = 1'b0;
                    w_mosi_nxt  = d_send[DATA_WIDTH-1];
                    w_cnt_nxt   = '0;
                    w_div_nxt   = '0;
                    w_state_nxt = ST_LEAD;
                end
            end
            ST_LEAD, ST_SCK_LO: begin
                if (w_div_last) begin
                    w_sck_nxt   = 1'b1;
                    w_rx_nxt    = {r_rx[DATA_WIDTH-2:0], miso};
                    w_state_nxt = ST_SCK_HI;
                end
            end
            ST_SCK_HI: begin
                if (w_div_last) begin
                    w_sck_nxt = 1'b0;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_TRAIL;
                    end else begin
                        w_tx_nxt    = r_tx << 1;
                        w_mosi_nxt  = r_tx[DATA_WIDTH-2];
                        w_state_nxt = ST_SCK_LO;
                    end
                end
            end
            ST_TRAIL: begin
                if (w_div_last) begin
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_drx_nxt   = r_rx;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_drx   <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b0;
            r_hold  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_drx   <= w_drx_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_done  <= w_done_nxt;
            r_hold  <= 1'b1;
        end
    end

    assign d_received       = r_drx;
    assign transfer_success = r_done;
    assign HOLD_ENABLE      = r_hold;
    assign mosi             = r_mosi;
    assign sck              = r_sck;
    assign cs_n             = r_cs_n;

endmodule

// File: tb/tb_spi_sram_master.sv
// Directed bench for spi_sram_master: a default-parameter instance (loopback or
// read-slave model on MISO) and a CLK_DIV=1 loopback instance.
module tb_spi_sram_master;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] d_send;
    logic        loopback;
    logic        mon_sel;

    logic [31:0] d_received0, d_received1;
    logic        done0, done1, hold0, hold1;
    logic        miso0, miso1, mosi0, mosi1, sck0, sck1, cs_n0, cs_n1;

    logic [31:0] slave_word;
    logic [5:0]  fall_cnt;

    int errors;
    int checks;

    logic        m_sck, m_mosi, m_cs_n, m_done;
    logic [31:0] m_drx;

    spi_sram_master #(.DATA_WIDTH(32), .CLK_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .d_send(d_send),
        .d_received(d_received0), .transfer_success(done0), .HOLD_ENABLE(hold0),
        .miso(miso0), .mosi(mosi0), .sck(sck0), .cs_n(cs_n0)
    );

    spi_sram_master #(.DATA_WIDTH(32), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .d_send(d_send),
        .d_received(d_received1), .transfer_success(done1), .HOLD_ENABLE(hold1),
        .miso(miso1), .mosi(mosi1), .sck(sck1), .cs_n(cs_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-slave: presents bit 31 when selected, advances on every SCK fall.
    initial fall_cnt = '0;
    always @(negedge sck0 or posedge cs_n0) begin
        if (cs_n0) fall_cnt <= '0;
        else if (fall_cnt < 6'd32) fall_cnt <= fall_cnt + 6'd1;
    end

    assign miso0 = loopback ? mosi0 :
                   (fall_cnt < 6'd32) ? slave_word[5'd31 - fall_cnt[4:0]] : 1'b0;
    assign miso1 = mosi1;

    assign m_sck  = mon_sel ? sck1 : sck0;
    assign m_mosi = mon_sel ? mosi1 : mosi0;
    assign m_cs_n = mon_sel ? cs_n1 : cs_n0;
    assign m_done = mon_sel ? done1 : done0;
    assign m_drx  = mon_sel ? d_received1 : d_received0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) tick();
    endtask

    // Raises enable for one edge; returns at the sample point of the start edge.
    task automatic start(input logic [31:0] word, input string name);
        d_send = word;
        enable = 1'b1;
        tick();
        checks++;
        if (m_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL %s start cs_n got=%b exp=0", name, m_cs_n);
        end
    endtask

    // Follows one transfer from t=0 until cs_n rises (400-cycle bound).
    task automatic watch(input bit busy, output int rises, output int first_rise,
                         output int last_fall, output int cs_rise, output int pulses,
                         output int pulse_t, output int viol, output logic [31:0] stream);
        logic prev_sck, prev_mosi, fell;
        rises = 0; first_rise = -1; last_fall = -1; cs_rise = -1;
        pulses = 0; pulse_t = -1; viol = 0; stream = '0;
        prev_sck = m_sck;
        prev_mosi = m_mosi;
        for (int t = 1; t <= 400 && cs_rise < 0; t++) begin
            if (busy) begin
                if (t == 10) d_send = 32'hDEADBEEF;
                enable = (t >= 10 && t <= 100) ? t[0] : 1'b0;
            end
            tick();
            fell = prev_sck && !m_sck;
            if (m_sck && !prev_sck) begin
                rises++;
                if (first_rise < 0) first_rise = t;
                stream = {stream[30:0], m_mosi};
            end
            if (fell) last_fall = t;
            if (m_done) begin pulses++; pulse_t = t; end
            if (m_cs_n) cs_rise = t;
            if (m_cs_n && m_sck) viol++;
            if (!m_cs_n && m_mosi !== prev_mosi && !fell) viol++;
            prev_sck = m_sck;
            prev_mosi = m_mosi;
        end
    endtask

    // Runs a transfer already started and checks timing, stream and result.
    task automatic verify_xfer(input string name, input bit busy, input int div,
                               input logic [31:0] exp_stream, input logic [31:0] exp_rx);
        int rises, first_rise, last_fall, cs_rise, pulses, pulse_t, viol;
        logic [31:0] stream;
        watch(busy, rises, first_rise, last_fall, cs_rise, pulses, pulse_t, viol, stream);
        checks += 8;
        if (rises !== 32) begin errors++; $display("FAIL %s sck_rises got=%0d exp=32", name, rises); end
        if (first_rise !== div) begin errors++; $display("FAIL %s first_rise got=%0d exp=%0d", name, first_rise, div); end
        if (last_fall !== 64 * div) begin errors++; $display("FAIL %s last_fall got=%0d exp=%0d", name, last_fall, 64 * div); end
        if (cs_rise !== 65 * div) begin errors++; $display("FAIL %s cs_rise got=%0d exp=%0d", name, cs_rise, 65 * div); end
        if (pulses !== 1 || pulse_t !== 65 * div) begin
            errors++;
            $display("FAIL %s pulse count=%0d at=%0d exp 1 at %0d", name, pulses, pulse_t, 65 * div);
        end
        if (viol !== 0) begin errors++; $display("FAIL %s protocol_violations got=%0d exp=0", name, viol); end
        if (stream !== exp_stream) begin errors++; $display("FAIL %s mosi_stream got=%h exp=%h", name, stream, exp_stream); end
        if (m_drx !== exp_rx) begin errors++; $display("FAIL %s d_received got=%h exp=%h", name, m_drx, exp_rx); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (cs_n0 !== 1'b1) begin errors++; $display("FAIL reset cs_n got=%b exp=1", cs_n0); end
        if (sck0 !== 1'b0) begin errors++; $display("FAIL reset sck got=%b exp=0", sck0); end
        if (mosi0 !== 1'b0) begin errors++; $display("FAIL reset mosi got=%b exp=0", mosi0); end
        if (done0 !== 1'b0) begin errors++; $display("FAIL reset transfer_success got=%b exp=0", done0); end
        if (d_received0 !== 32'h0) begin errors++; $display("FAIL reset d_received got=%h exp=0", d_received0); end
        if (hold0 !== 1'b1) begin errors++; $display("FAIL reset HOLD_ENABLE got=%b exp=1", hold0); end
        rst = 1'b1;
        idle(3);
    endtask

    task automatic test_loopback();
        mon_sel = 1'b0;
        loopback = 1'b1;
        start(32'hA5C30F81, "loopback");
        enable = 1'b0;
        verify_xfer("loopback", 1'b0, 2, 32'hA5C30F81, 32'hA5C30F81);
        tick();
        checks++;
        if (done0 !== 1'b0) begin errors++; $display("FAIL loopback pulse_width got=%b exp=0", done0); end
        idle(150);
    endtask

    task automatic test_slave_read();
        mon_sel = 1'b0;
        loopback = 1'b0;
        slave_word = 32'h12345678;
        start(32'h03000000, "slave_read");
        enable = 1'b0;
        verify_xfer("slave_read", 1'b0, 2, 32'h03000000, 32'h12345678);
        loopback = 1'b1;
        idle(150);
    endtask

    task automatic test_back_to_back();
        mon_sel = 1'b0;
        loopback = 1'b1;
        start(32'hFFFFFFFF, "b2b_first");
        d_send = 32'h00000001;
        verify_xfer("b2b_first", 1'b0, 2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        checks++;
        if (cs_n0 !== 1'b0) begin errors++; $display("FAIL b2b restart cs_n got=%b exp=0", cs_n0); end
        enable = 1'b0;
        verify_xfer("b2b_second", 1'b0, 2, 32'h00000001, 32'h00000001);
        idle(150);
    endtask

    task automatic test_clk_div1();
        mon_sel = 1'b1;
        start(32'h80000001, "clk_div1");
        enable = 1'b0;
        verify_xfer("clk_div1", 1'b0, 1, 32'h80000001, 32'h80000001);
        mon_sel = 1'b0;
        idle(150);
    endtask

    task automatic test_busy();
        mon_sel = 1'b0;
        loopback = 1'b1;
        start(32'h0F0F0F0F, "busy");
        enable = 1'b0;
        verify_xfer("busy", 1'b1, 2, 32'h0F0F0F0F, 32'h0F0F0F0F);
        idle(150);
    endtask

    task automatic test_abort_reset();
        int pulses, selects;
        mon_sel = 1'b0;
        loopback = 1'b1;
        start(32'hCAFEF00D, "abort");
        enable = 1'b0;
        repeat (40) tick();
        rst = 1'b0;
        #1;
        checks += 6;
        if (cs_n0 !== 1'b1) begin errors++; $display("FAIL abort cs_n got=%b exp=1", cs_n0); end
        if (sck0 !== 1'b0) begin errors++; $display("FAIL abort sck got=%b exp=0", sck0); end
        if (mosi0 !== 1'b0) begin errors++; $display("FAIL abort mosi got=%b exp=0", mosi0); end
        if (done0 !== 1'b0) begin errors++; $display("FAIL abort transfer_success got=%b exp=0", done0); end
        if (d_received0 !== 32'h0) begin errors++; $display("FAIL abort d_received got=%h exp=0", d_received0); end
        if (hold0 !== 1'b1) begin errors++; $display("FAIL abort HOLD_ENABLE got=%b exp=1", hold0); end
        tick();
        rst = 1'b1;
        pulses = 0;
        selects = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done0) pulses++;
            if (!cs_n0) selects++;
        end
        checks += 3;
        if (pulses !== 0) begin errors++; $display("FAIL abort late_pulses got=%0d exp=0", pulses); end
        if (selects !== 0) begin errors++; $display("FAIL abort cs_low_cycles got=%0d exp=0", selects); end
        if (d_received0 !== 32'h0) begin errors++; $display("FAIL abort d_received_after got=%h exp=0", d_received0); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        enable = 1'b0;
        d_send = '0;
        loopback = 1'b1;
        mon_sel = 1'b0;
        slave_word = '0;

        test_reset();
        test_loopback();
        test_slave_read();
        test_back_to_back();
        test_clk_div1();
        test_busy();
        test_abort_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
